// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter and the memory-mapped bus decode.
// State encoding, port indices and the bus I/O address map live here.
package dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DBITS_DEF = 32;

    // Memory-mapped device addresses decoded downstream of the arbiter
    localparam logic [31:0] ADDRHEX  = 32'hF000_0000;
    localparam logic [31:0] ADDRLEDR = 32'hF000_0004;
    localparam logic [31:0] ADDRLEDG = 32'hF000_0008;
    localparam logic [31:0] ADDRKEY  = 32'hF000_0010;
    localparam logic [31:0] ADDRSW   = 32'hF000_0014;

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// port the pointer names.
module rr_pick2
    import dbus_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    assign gnt0_o = req0_i & (~req1_i | (ptr_i == PORT0));
    assign gnt1_o = req1_i & (~req0_i | (ptr_i == PORT1));

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the data bus between the memory stage (port 0) and a second master
// (port 1) with round-robin arbitration, bounded locking and tagged read returns.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int DBITS    = DBITS_DEF,
    parameter int LOCKMAX  = 8,
    parameter int LCNTBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic             m0_lock,
    input  logic [DBITS-1:0] m0_addr,
    input  logic [DBITS-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [DBITS-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic             m1_lock,
    input  logic [DBITS-1:0] m1_addr,
    input  logic [DBITS-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [DBITS-1:0] m1_rdata,
    output logic             s_en,
    output logic             s_we,
    output logic [DBITS-1:0] s_addr,
    output logic [DBITS-1:0] s_wdata,
    input  logic [DBITS-1:0] s_rdata
);

    arb_state_e          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [LCNTBITS-1:0] lockCnt_q, lockCnt_d;
    logic                idle_q, idle_d;
    logic                rdPend_q, rdTag_q;
    logic [DBITS-1:0]    rdata0_q, rdata1_q;

    logic pickGnt0, pickGnt1;
    logic gnt0, gnt1;
    logic ownReq, ownLock, ownIsM1;

    rr_pick2 uPick (
        .req0_i (m0_req),
        .req1_i (m1_req),
        .ptr_i  (ptr_q),
        .gnt0_o (pickGnt0),
        .gnt1_o (pickGnt1)
    );

    assign ownIsM1 = (state_q == LOCK1);
    assign ownReq  = ownIsM1 ? m1_req  : m0_req;
    assign ownLock = ownIsM1 ? m1_lock : m0_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= PORT0;
            lockCnt_q <= '0;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lockCnt_q <= lockCnt_d;
            idle_q    <= idle_d;
        end
    end

    // A burst ends on an unlocked grant, on its LOCKMAX-th grant (pointer then
    // favours the other port), or after two idle cycles from the lock owner.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lockCnt_d = lockCnt_q;
        idle_d    = idle_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state_q)
            ARB: begin
                gnt0   = pickGnt0;
                gnt1   = pickGnt1;
                idle_d = 1'b0;
                if (pickGnt0 | pickGnt1) begin
                    ptr_d = pickGnt1 ? PORT0 : PORT1;
                    if ((pickGnt0 & m0_lock) | (pickGnt1 & m1_lock)) begin
                        state_d   = pickGnt1 ? LOCK1 : LOCK0;
                        lockCnt_d = LCNTBITS'(1);
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (ownReq) begin
                    gnt0   = ~ownIsM1;
                    gnt1   = ownIsM1;
                    idle_d = 1'b0;
                    ptr_d  = ownIsM1 ? PORT0 : PORT1;
                    if (!ownLock || lockCnt_q == LCNTBITS'(LOCKMAX - 1)) begin
                        state_d   = ARB;
                        lockCnt_d = '0;
                    end else begin
                        lockCnt_d = lockCnt_q + 1'b1;
                    end
                end else if (idle_q) begin
                    state_d   = ARB;
                    lockCnt_d = '0;
                    idle_d    = 1'b0;
                end else begin
                    idle_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign s_en   = gnt0 | gnt1;

    always_comb begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt1) begin
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end else if (gnt0) begin
            s_we    = m0_we;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end
    end

    // The tag remembers which port issued the read so the returning data is
    // steered correctly even when reads from alternate ports are back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPend_q <= 1'b0;
            rdTag_q  <= PORT0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdPend_q <= s_en & ~s_we;
            rdTag_q  <= gnt1 ? PORT1 : PORT0;
            if (rdPend_q && rdTag_q == PORT0) rdata0_q <= s_rdata;
            if (rdPend_q && rdTag_q == PORT1) rdata1_q <= s_rdata;
        end
    end

    assign m0_rvalid = rdPend_q & (rdTag_q == PORT0);
    assign m1_rvalid = rdPend_q & (rdTag_q == PORT1);
    assign m0_rdata  = m0_rvalid ? s_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? s_rdata : rdata1_q;

endmodule
